// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ifu_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_perf_counters.sv
// Fetch-unit event counters: consumed instructions and stalled HOLD cycles.
// Latency: counts visible the cycle after the event edge.
// Backpressure: none; counters wrap at 2^32.
// Ports: clock, reset_n (sync, active-low), consume / hold_stall event strobes,
//        fetch_count / stall_count count outputs.
module ifu_perf_counters (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        consume,
    input  logic        hold_stall,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (consume)    fetch_count <= fetch_count + 32'd1;
            if (hold_stall) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues one imem request at a time, feeds IF/ID.
// Latency: if_valid rises the edge after imem_rvalid; best case 1 instr / 3 cycles.
// Backpressure: stall holds the fetched instruction in HOLD; no new request is issued.
// Ports: clock, reset_n (sync, active-low); stall, branch_taken/branch_target from
//        the pipeline; imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata memory
//        side; if_instruction/if_pc/if_valid to IF/ID.
// Option: define IFU_PERF_COUNTERS_EN to add fetch_count / stall_count outputs.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    ifu_state_t  state, state_n;
    logic [31:0] pc, pc_n;
    logic        kill, kill_n;
    logic [31:0] instr_n, ipc_n;
    logic        ivld_n;
    logic        accept;
    logic        consume;

    assign imem_req  = reset_n && (state == FETCH);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    // A branch out of HOLD flushes the instruction rather than handing it over.
    assign consume   = (state == HOLD) && !stall && !branch_taken;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        instr_n = if_instruction;
        ipc_n   = if_pc;
        ivld_n  = if_valid;

        if (branch_taken) begin
            pc_n = align(branch_target);
        end

        unique case (state)
            FETCH: begin
                if (accept) begin
                    state_n = WAIT;
                    // Data already requested belongs to the old path.
                    if (branch_taken) kill_n = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // A response arriving with a branch or a pending kill is
                    // stale; it closes the only outstanding request, so the
                    // kill is spent here and the refetch runs unkilled.
                    if (kill || branch_taken) begin
                        kill_n  = 1'b0;
                        state_n = FETCH;
                    end else begin
                        instr_n = imem_rdata;
                        ipc_n   = pc;
                        ivld_n  = 1'b1;
                        state_n = HOLD;
                    end
                end else if (branch_taken) begin
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken || !stall) begin
                    ivld_n  = 1'b0;
                    instr_n = NOP_INSTR;
                    state_n = FETCH;
                    if (!branch_taken) pc_n = pc + PC_STEP;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            if_instruction <= NOP_INSTR;
            if_pc          <= 32'd0;
            if_valid       <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            kill           <= kill_n;
            if_instruction <= instr_n;
            if_pc          <= ipc_n;
            if_valid       <= ivld_n;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    ifu_perf_counters u_perf (
        .clock       (clock),
        .reset_n     (reset_n),
        .consume     (consume),
        .hold_stall  ((state == HOLD) && stall),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later so registered state has settled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_if(input string tag, input logic vld, input logic [31:0] pc,
                            input logic [31:0] ins);
        check_eq({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
        check_eq({tag, ".pc"}, if_pc, pc);
        check_eq({tag, ".instr"}, if_instruction, ins);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check_eq({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        #1;
        tick(); tick();
        check_if("reset", 1'b0, 32'd0, NOP);
        check_req("reset", 1'b0, 32'd0);

        // Basic fetch at RESET_PC.
        reset_n = 1'b1; imem_ready = 1'b1; #1;
        check_req("fetch0", 1'b1, 32'h0);
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
        check_req("wait0", 1'b0, 32'h0);
        tick();
        imem_rvalid = 1'b0;
        check_if("hold0", 1'b1, 32'h0, 32'h0050_0093);
        check_req("hold0", 1'b0, 32'h0);

        // Three stalled HOLD cycles keep the outputs frozen.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_if("stall", 1'b1, 32'h0, 32'h0050_0093);
            check_eq("stall.req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check_if("consume0", 1'b0, 32'h0, NOP);
        check_req("consume0", 1'b1, 32'h4);

        // Branch while WAITing: late response is discarded.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        check_req("br_wait", 1'b0, 32'h100);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check_if("br_wait_drop", 1'b0, 32'h0, NOP);
        check_req("br_wait_refetch", 1'b1, 32'h100);

        // Branch coinciding with acceptance: data for 0x100 is killed.
        imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        imem_ready = 1'b0; branch_taken = 1'b0;
        check_req("br_acc", 1'b0, 32'h200);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        check_if("br_acc_drop", 1'b0, 32'h0, NOP);
        check_req("br_acc_refetch", 1'b1, 32'h200);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        imem_rvalid = 1'b0;
        check_if("fetch200", 1'b1, 32'h200, 32'h2222_2222);

        // Branch from HOLD flushes; unaligned target is aligned.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        check_if("br_hold", 1'b0, 32'h200, NOP);
        check_req("br_hold", 1'b1, 32'hFFFF_FFFC);

        // PC wrap on consume of 0xFFFF_FFFC.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        imem_rvalid = 1'b0;
        check_if("fetch_top", 1'b1, 32'hFFFF_FFFC, 32'h3333_3333);
        tick();
        check_req("wrap", 1'b1, 32'h0);

        // Branch in FETCH without acceptance retargets the pending request.
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check_req("br_fetch", 1'b1, 32'h40);

`ifdef IFU_PERF_COUNTERS_EN
        check_eq("fetch_count", fetch_count, 32'd2);
        check_eq("stall_count", stall_count, 32'd4);
`endif

        // Reset during WAIT with a response arriving under reset.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; reset_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; #1;
        check_eq("rst_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        check_if("rst_mid", 1'b0, 32'h0, NOP);
        imem_rvalid = 1'b0; reset_n = 1'b1; #1;
        check_req("rst_release", 1'b1, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
        check_eq("fetch_count_rst", fetch_count, 32'd0);
        check_eq("stall_count_rst", stall_count, 32'd0);
`endif
        // Stray rvalid in FETCH is ignored.
        imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_rvalid = 1'b0;
        check_if("stray_rvalid", 1'b0, 32'h0, NOP);
        check_req("stray_rvalid", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
